// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: two-level loop sequencer for the outer (ARG) and inner (ART)
// loop-counter registers. Loads both reference bounds, clears both counters,
// then walks a nested loop, handing each body iteration to the datapath with a
// body_req/body_ack handshake. Exactly one counter strobe is active per cycle,
// so the counter registers' fixed strobe priority never comes into play.
module loop_seq_ctrl #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] bound_outer,
  input  logic [W-1:0] bound_inner,
  input  logic         z_outer,
  input  logic         z_inner,
  input  logic         body_ack,
  output logic         o_inc,
  output logic         o_reset,
  output logic         o_cin_ref,
  output logic         i_inc,
  output logic         i_reset,
  output logic         i_cin_ref,
  output logic [W-1:0] d_to_ADR,
  output logic         body_req,
  output logic         busy,
  output logic         done
);

  typedef enum logic [3:0] {
    StIdle,
    StLdRefO,
    StLdRefI,
    StClrO,
    StClrI0,
    StBody,
    StIncI,
    StSetI,
    StIncO,
    StSetO,
    StClrI,
    StDone
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] bound_outer_q, bound_inner_q;
  logic         load_bounds;
  logic         zero_bound;

  // A zero trip count in either level means the body never runs.
  assign zero_bound = (bound_outer == '0) || (bound_inner == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Bound latches; held for the whole nest so mid-nest input changes are inert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bound_outer_q <= '0;
      bound_inner_q <= '0;
    end else if (load_bounds) begin
      bound_outer_q <= bound_outer;
      bound_inner_q <= bound_inner;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_d     = state_q;
    load_bounds = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load_bounds = 1'b1;
          state_d     = zero_bound ? StDone : StLdRefO;
        end
      end
      StLdRefO: state_d = StLdRefI;
      StLdRefI: state_d = StClrO;
      StClrO:   state_d = StClrI0;
      StClrI0:  state_d = StBody;
      StBody: begin
        if (body_ack) begin
          state_d = StIncI;
        end
      end
      StIncI:   state_d = StSetI;
      // Z is only meaningful one cycle after an increment.
      StSetI:   state_d = z_inner ? StIncO : StBody;
      StIncO:   state_d = StSetO;
      StSetO:   state_d = z_outer ? StDone : StClrI;
      StClrI:   state_d = StBody;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      load_bounds = 1'b0;
    end
  end

  // Moore output decode; every output is a pure function of the state.
  always_comb begin
    o_inc     = 1'b0;
    o_reset   = 1'b0;
    o_cin_ref = 1'b0;
    i_inc     = 1'b0;
    i_reset   = 1'b0;
    i_cin_ref = 1'b0;
    d_to_ADR  = '0;
    body_req  = 1'b0;
    busy      = (state_q != StIdle);
    done      = 1'b0;
    unique case (state_q)
      StLdRefO: begin
        o_cin_ref = 1'b1;
        d_to_ADR  = bound_outer_q;
      end
      StLdRefI: begin
        i_cin_ref = 1'b1;
        d_to_ADR  = bound_inner_q;
      end
      StClrO:   o_reset  = 1'b1;
      StClrI0:  i_reset  = 1'b1;
      StBody:   body_req = 1'b1;
      StIncI:   i_inc    = 1'b1;
      StIncO:   o_inc    = 1'b1;
      StClrI:   i_reset  = 1'b1;
      StDone:   done     = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Bench for loop_seq_ctrl: models the two external counter registers, and
// checks each nest against trip counts and cycle totals derived from the
// loop arithmetic (O*I bodies, 5 + 3*O*I + 3*O - 1 cycles plus ack stalls).
module tb_loop_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [8:0] bound_outer;
  logic [8:0] bound_inner;
  logic       z_outer;
  logic       z_inner;
  logic       body_ack;
  logic       o_inc, o_reset, o_cin_ref;
  logic       i_inc, i_reset, i_cin_ref;
  logic [8:0] d_to_ADR;
  logic       body_req, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  loop_seq_ctrl #(.W(9)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .bound_outer (bound_outer),
    .bound_inner (bound_inner),
    .z_outer     (z_outer),
    .z_inner     (z_inner),
    .body_ack    (body_ack),
    .o_inc       (o_inc),
    .o_reset     (o_reset),
    .o_cin_ref   (o_cin_ref),
    .i_inc       (i_inc),
    .i_reset     (i_reset),
    .i_cin_ref   (i_cin_ref),
    .d_to_ADR    (d_to_ADR),
    .body_req    (body_req),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Behavioural counter registers (inc > reset > cin_ref); Z = count equals reference.
  logic [8:0] o_cnt = '0, o_ref = '0, i_cnt = '0, i_ref = '0;
  always @(posedge clk) begin
    if (o_inc) o_cnt <= o_cnt + 9'd1;
    else if (o_reset) o_cnt <= '0;
    else if (o_cin_ref) o_ref <= d_to_ADR;
    if (i_inc) i_cnt <= i_cnt + 9'd1;
    else if (i_reset) i_cnt <= '0;
    else if (i_cin_ref) i_ref <= d_to_ADR;
  end
  assign z_outer = (o_cnt == o_ref);
  assign z_inner = (i_cnt == i_ref);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {o_inc, o_reset, o_cin_ref, i_inc, i_reset, i_cin_ref,
            body_req, busy, done, d_to_ADR};
  endfunction

  // One full nest: start at the next edge, then run until done (or budget).
  task automatic run_nest(input int bo, input int bi, input int dmin, input int dmax,
                          input bit tie_ack, input int busy_start_at);
    int  cyc, bodies, delay_sum, wait_cnt, req_cycles, strobes, exp_done, exp_d;
    bit  prev_req, prev_acked, seen_done, zero;
    zero       = (bo == 0) || (bi == 0);
    exp_done   = zero ? 1 : 5 + 3 * bo * bi + 3 * bo - 1;
    cyc        = 0;
    bodies     = 0;
    delay_sum  = 0;
    wait_cnt   = 0;
    req_cycles = 0;
    prev_req   = 1'b0;
    prev_acked = 1'b0;
    seen_done  = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    bound_outer = 9'(bo);
    bound_inner = 9'(bi);
    body_ack    = tie_ack;
    while (!seen_done && cyc < 5000) begin
      @(negedge clk);
      cyc = cyc + 1;
      strobes = int'(o_inc) + int'(o_reset) + int'(o_cin_ref)
              + int'(i_inc) + int'(i_reset) + int'(i_cin_ref);
      check("strobe_onehot", 32'(strobes <= 1), 1);
      check("busy", 32'(busy), 1);
      if (zero) check("zero_no_strobe", 32'(strobes), 0);
      exp_d = (!zero && cyc == 1) ? bo : (!zero && cyc == 2) ? bi : 0;
      check("d_to_ADR", 32'(d_to_ADR), 32'(exp_d));
      if (i_inc) check("inc_after_ack", 32'(prev_acked), 1);
      if (o_inc) check("inner_wrap", 32'(i_cnt), 32'(bi));
      if (done) seen_done = 1'b1;
      // Drive inputs for the coming edge; bounds are scrambled to prove latching.
      start = (cyc == busy_start_at);
      if (start) begin
        bound_outer = 9'd7;
        bound_inner = 9'd7;
      end else begin
        bound_outer = 9'($urandom_range(0, 511));
        bound_inner = 9'($urandom_range(0, 511));
      end
      if (body_req) begin
        req_cycles = req_cycles + 1;
        if (!prev_req) begin
          wait_cnt  = $urandom_range(dmax, dmin);
          delay_sum = delay_sum + wait_cnt;
        end
        body_ack = (wait_cnt == 0);
        if (wait_cnt > 0) wait_cnt = wait_cnt - 1;
      end else begin
        body_ack = tie_ack;
      end
      if (body_req && body_ack) bodies = bodies + 1;
      prev_acked = body_req && body_ack;
      prev_req   = body_req;
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("done_cycle", 32'(cyc), 32'(exp_done + delay_sum));
    check("bodies", 32'(bodies), 32'(bo * bi));
    check("req_cycles", 32'(req_cycles), 32'(bo * bi + delay_sum));
    if (!zero) check("outer_final", 32'(o_cnt), 32'(bo));
    start    = 1'b0;
    body_ack = 1'b0;
    @(negedge clk);
    check("idle_after_done", 32'({busy, done}), 0);
  endtask

  initial begin
    int cyc, nreq;
    bit prev_req;
    reset       = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    bound_outer = '0;
    bound_inner = '0;
    body_ack    = 1'b0;
    #2;
    check("reset_outputs", 32'(all_outs()), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'(all_outs()), 0);

    // Nominal 2/3 with ack tied high: done in cycle 28.
    run_nest(2, 3, 0, 0, 1'b1, -1);
    // Zero inner bound: done in cycle 1, no strobes.
    run_nest(5, 0, 0, 0, 1'b0, -1);
    // Handshake stall: each body held 5 cycles.
    run_nest(1, 2, 4, 4, 1'b0, -1);
    // Start while busy (7/7) is ignored during a 2/2 nest.
    run_nest(2, 2, 0, 0, 1'b0, 7);
    // Random bounds and ack delays.
    for (int r = 0; r < 6; r++) begin
      run_nest($urandom_range(1, 8), $urandom_range(1, 8), 0, 3, 1'b0, -1);
    end

    // Abort during the third BODY of a 3/3 nest.
    @(negedge clk);
    start       = 1'b1;
    bound_outer = 9'd3;
    bound_inner = 9'd3;
    cyc         = 0;
    nreq        = 0;
    prev_req    = 1'b0;
    while (nreq < 3 && cyc < 200) begin
      @(negedge clk);
      cyc   = cyc + 1;
      start = 1'b0;
      if (body_req && !prev_req) nreq = nreq + 1;
      prev_req = body_req;
      body_ack = body_req && (nreq < 3);
      abort    = body_req && (nreq == 3);
    end
    check("abort_body_cycle", 32'(cyc), 11);
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'(all_outs()), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'({busy, done}), 0);
    end

    // Asynchronous reset mid-BODY.
    start       = 1'b1;
    bound_outer = 9'd2;
    bound_inner = 9'd2;
    cyc         = 0;
    @(negedge clk);
    start = 1'b0;
    while (!body_req && cyc < 50) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    check("reach_body", 32'(body_req), 1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(all_outs()), 0);
    @(negedge clk);
    reset = 1'b0;
    run_nest(1, 1, 0, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/loop_seq_ctrl.md
# loop_seq_ctrl

Two-level loop sequencer driving the pair of loop-counter registers (outer = ARG, inner = ART) in the processor datapath. On `start` it loads both reference bounds, clears both counters, then steps through a nested loop. Each body iteration is handed to the datapath with a `body_req`/`body_ack` handshake. It emits exactly one counter strobe per cycle, because the counter registers resolve simultaneous strobes by fixed priority (inc > dec > reset > cin > cin_ref).

## Interface
- `W`, default 9: counter/bound width; matches the counter registers.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and all outputs low.
- `start`  in  1  begin a loop nest; sampled only in IDLE.
- `abort`  in  1  synchronous; from any non-IDLE state, go to IDLE without `done`.
- `bound_outer`  in  W  outer trip count; latched on accepted `start`.
- `bound_inner`  in  W  inner trip count; latched on accepted `start`.
- `z_outer`, `z_inner`  in  1  Z_OUT of the outer/inner counter registers.
- `body_ack`  in  1  datapath finished current body iteration.
- `o_inc`, `o_reset`, `o_cin_ref`  out  1  strobes to the outer counter.
- `i_inc`, `i_reset`, `i_cin_ref`  out  1  strobes to the inner counter.
- `d_to_ADR`  out  W  bound value presented during reference loads; 0 otherwise.
- `body_req`  out  1  body iteration pending.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the nest completes.

## Operation
- All outputs are decoded from the registered state (Moore). All are 0 after reset; `d_to_ADR` = 0.
- `dec`, `cin` and the unused counter strobes are tied low by the integrator.
- States and transitions:
  - IDLE: on `start`, latch both bounds. If either bound is 0, go to DONE; else go to LD_REF_O.
  - LD_REF_O: `o_cin_ref`=1, `d_to_ADR`=bound_outer. Then LD_REF_I.
  - LD_REF_I: `i_cin_ref`=1, `d_to_ADR`=bound_inner. Then CLR_O.
  - CLR_O: `o_reset`=1. Then CLR_I0.
  - CLR_I0: `i_reset`=1. Then BODY.
  - BODY: `body_req`=1. Stay until `body_ack` is sampled high, then INC_I.
  - INC_I: `i_inc`=1. Then SET_I.
  - SET_I: settle cycle; sample `z_inner`. If 1, go to INC_O; else go to BODY.
  - INC_O: `o_inc`=1. Then SET_O.
  - SET_O: settle cycle; sample `z_outer`. If 1, go to DONE; else go to CLR_I.
  - CLR_I: `i_reset`=1. Then BODY.
  - DONE: `done`=1. Then IDLE.
- Z inputs are sampled only in SET_I/SET_O, i.e. one cycle after an increment. Z is never trusted after a clear or a reference load, because Z only re-evaluates when the counter value changes.
- Zero bounds are handled entirely inside this block; counters are left untouched.
- Body executes bound_outer × bound_inner times. Counter indices run 0..bound−1 during BODY.
- `abort` has priority over all transitions except `reset`. It is ignored in IDLE.
- `start` while busy is ignored. A new `start` is accepted in the cycle after DONE (in IDLE).
- `body_ack` outside BODY is ignored.
- Latched bounds are stable for the whole nest; input bound changes mid-nest have no effect.

## Timing
- Accepted `start` at edge k: LD_REF_O during cycle k+1, first `body_req` in cycle k+5.
- Zero-bound case: `done` high in cycle k+1.
- Per inner iteration with immediate ack: 3 cycles (BODY, INC_I, SET_I).
- Per outer wrap: +2 cycles (INC_O, SET_O), plus 1 (CLR_I) if not final.
- Total from `start` to `done` with immediate ack: 5 + 3·O·I + 2·O + (O−1) cycles, where O = bound_outer and I = bound_inner.
- Maximum bound 2^W−1 (511). Increments never wrap the counter.
- Asynchronous `reset` mid-nest: outputs low immediately, state IDLE. Counter contents are undefined and are reloaded on the next `start`.

## Test plan
- Nominal nest: bounds 2/3, `body_ack` tied high, `start` at edge 0 → 6 `body_req` cycles; `done` in cycle 28; `busy` high during cycles 1–28.
- Zero bound: bound_inner=0, bound_outer=5 → `done` in cycle 1; no counter strobe ever asserted.
- Handshake stall: bounds 1/2, ack delayed 4 cycles per body → each `body_req` held 5 cycles; `i_inc` fires only after ack; exactly 2 bodies.
- Strobe exclusivity: random bounds 1..8 and random ack delays → at most one of the six strobes high per cycle; inner counter model reads bound_inner exactly at each SET_I wrap.
- Abort/reset: `abort` during 3rd BODY of 3/3 → IDLE next cycle, no `done`. Async `reset` mid-BODY → all outputs 0 before the next edge. A following `start` with 1/1 completes normally.
- Start while busy: second `start` with bounds 7/7 during a 2/2 nest → ignored; exactly 4 bodies run.
